// File: rtl/rca_serial_sub_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rca_serial_sub_if
// Purpose  : Bundles the operand-side and result-side valid/ready handshakes
//            of the digit-serial subtractor.
// Ports    : in_valid/in_ready/a/b/bin  - operand channel (producer -> block)
//            out_valid/out_ready        - result channel (block -> consumer)
//            diff/bout/ovf/zero         - result payload
// Revision : 1.0 - initial release
// ============================================================================
interface rca_serial_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface
`default_nettype wire

// File: rtl/rca_serial_sub.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rca_serial_sub
// Purpose  : Multi-cycle two's-complement subtractor. Computes a - b - bin one
//            DIGIT-bit slice per clock, LSB slice first, rippling the borrow
//            through a registered borrow flop.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - rca_serial_sub_if.slave (operand and result handshakes,
//                    diff / bout / ovf / zero result flags)
// Revision : 1.0 - initial release
// ============================================================================
module rca_serial_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rca_serial_sub_if.slave     bus
);

  localparam int c_nslice = WIDTH / DIGIT;
  localparam int c_cw     = (c_nslice > 1) ? $clog2(c_nslice) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_nslice - 1);

  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("rca_serial_sub: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;        // shifted right one slice per RUN cycle
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [c_cw-1:0]  r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [DIGIT:0]   w_sub;      // {borrow', d}: top bit set when slice underflows
  logic [WIDTH-1:0] w_diff_next;
  logic             w_last;

  // Current slice always sits in the low DIGIT bits of the shifted operands.
  assign w_sub  = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]}
                - {{DIGIT{1'b0}}, r_borrow};
  assign w_last = (r_cnt == c_last);

  // Merge the new slice into the partial result; untouched slices stay 0.
  always_comb begin
    w_diff_next = r_diff;
    for (int k = 0; k < c_nslice; k++) begin
      if (r_cnt == c_cw'(k)) begin
        w_diff_next[k*DIGIT +: DIGIT] = w_sub[DIGIT-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_borrow    <= 1'b0;
      r_cnt       <= '0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_borrow   <= bus.bin;
            r_cnt      <= '0;
            r_diff     <= '0;
            r_bout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_diff   <= w_diff_next;
          r_borrow <= w_sub[DIGIT];
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            // On the last slice r_a/r_b low slices hold the operand MSBs.
            r_bout      <= w_sub[DIGIT];
            r_ovf       <= (r_a[DIGIT-1] != r_b[DIGIT-1])
                        && (w_sub[DIGIT-1] != r_a[DIGIT-1]);
            r_zero      <= (w_diff_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_rca_serial_sub.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rca_serial_sub
// Purpose  : Self-checking bench for rca_serial_sub (directed plus random
//            operations, scoreboard queue checked by an output monitor).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rca_serial_sub;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zero;
    int           acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   cyc;
  int   rdy_mode;     // 0: out_ready=1, 1: random, 2: out_ready=0
  logic prev_ov;
  exp_t pend;
  exp_t q[$];

  rca_serial_sub_if #(.WIDTH(W)) ifc ();

  rca_serial_sub #(.WIDTH(W), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definition.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    longint diff_i;
    diff_i = longint'(a) - longint'(b) - longint'(bin);
    e.d    = W'(diff_i & ((64'd1 << W) - 1));
    e.bout = (longint'(a) < longint'(b) + longint'(bin));
    e.ovf  = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    e.zero = (e.d == '0);
    e.acc  = 0;
    return e;
  endfunction

  // Accept detector: pushes the pending expectation when a handshake happens.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && ifc.in_valid && ifc.in_ready) begin
      exp_t e;
      e     = pend;
      e.acc = cyc;
      q.push_back(e);
    end
  end

  // out_ready driver.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ifc.out_ready = 1'b1;
      1:       ifc.out_ready = 1'($urandom_range(0, 1));
      default: ifc.out_ready = 1'b0;
    endcase
  end

  // Monitor: compares every presented result against the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (ifc.out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 32'(ifc.out_valid), 32'd0);
        end else begin
          if (!prev_ov) check("latency", 32'(cyc - q[0].acc), 32'd4);
          check("diff", 32'(ifc.diff), 32'(q[0].d));
          check("bout", 32'(ifc.bout), 32'(q[0].bout));
          check("ovf",  32'(ifc.ovf),  32'(q[0].ovf));
          check("zero", 32'(ifc.zero), 32'(q[0].zero));
          if (ifc.out_ready) void'(q.pop_front());
        end
      end
      prev_ov = ifc.out_valid;
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    ifc.a        = a;
    ifc.b        = b;
    ifc.bin      = bin;
    ifc.in_valid = 1'b1;
  endtask

  // Hold in_valid until accepted, then drop it.
  task automatic wait_accept();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (ifc.in_ready) begin
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.a        = W'($urandom);   // post-accept changes must not matter
        ifc.b        = W'($urandom);
        ifc.bin      = 1'($urandom);
        done         = 1;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] d, input logic bo, input logic ov, input logic z);
    pend.d = d; pend.bout = bo; pend.ovf = ov; pend.zero = z; pend.acc = 0;
    @(posedge clk); #1;
    drive(a, b, bin);
    wait_accept();
  endtask

  task automatic send_rand(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    pend = model(a, b, bin);
    @(posedge clk); #1;
    drive(a, b, bin);
    wait_accept();
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !ifc.out_valid) done = 1;
    end
    if (!done) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_out_valid();
    bit done;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (ifc.out_valid) done = 1;
    end
    if (!done) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; rdy_mode = 0; prev_ov = 1'b0;
    pend = '{d: '0, bout: 1'b0, ovf: 1'b0, zero: 1'b0, acc: 0};
    ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.bin = 1'b0; ifc.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready",  32'(ifc.in_ready),  32'd1);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_diff",      32'(ifc.diff),      32'd0);
    check("rst_flags",     32'({ifc.bout, ifc.ovf, ifc.zero}), 32'd0);
    rst_n = 1'b1;

    // Directed edge values.
    send_dir(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    send_dir(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    send_dir(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    send_dir(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    send_dir(16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    send_dir(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    send_dir(16'hABCD, 16'hABCD, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    drain();

    // Backpressure with a new operand waiting.
    rdy_mode = 2;
    send_dir(16'h4321, 16'h1111, 1'b1, 16'h320F, 1'b0, 1'b0, 1'b0);
    wait_out_valid();
    #1;
    pend.d = 16'h0FFF; pend.bout = 1'b0; pend.ovf = 1'b0; pend.zero = 1'b0; pend.acc = 0;
    drive(16'h2000, 16'h1000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
    end
    rdy_mode = 0;
    wait_accept();
    drain();

    // Asynchronous reset in the second RUN cycle.
    pend.d = 16'h0001; pend.bout = 1'b0; pend.ovf = 1'b0; pend.zero = 1'b0;
    @(posedge clk); #1;
    drive(16'h0002, 16'h0001, 1'b0);
    wait_accept();            // returns #1 after the accept edge
    @(posedge clk); #2;       // now inside the second RUN cycle
    rst_n = 1'b0;
    #1;
    q.delete();
    check("arst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("arst_diff",      32'(ifc.diff),      32'd0);
    check("arst_in_ready",  32'(ifc.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale_out_valid", 32'(ifc.out_valid), 32'd0);
    end
    send_dir(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);
    drain();

    // Random operations with random consumer backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (i % 7 == 0) ? ra : W'($urandom);
      send_rand(ra, rb, 1'($urandom));
    end
    drain();
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
